tact_debouncer: RTL
===================

Name: tact_debouncer

Overview:
- Front-end conditioner for the board tact switch, upstream of the reset-pulse generator.
- Synchronizes the raw, bouncing, asynchronous switch input to Clock.
- Debounces it with a counter-qualified 4-state FSM.
- Outputs:
  - a clean level;
  - single-cycle press and release events;
  - a one-shot long-press event, which the reset generator consumes as its trigger.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the input synchronizer chain (min 2).
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronized samples required to accept a level change (min 2).
- LONG_PRESS_CYCLES, 2000000, cycles spent in HELD before LongPress fires (must be > DEBOUNCE_CYCLES).
- TACT_ACTIVE_LOW, 1, 1 = switch pulls Tact low when pressed; 0 = high when pressed.

Ports:
- Clock  input  1  system clock; single clock domain.
- Reset_n  input  1  asynchronous, active-low reset.
- Tact  input  1  raw switch pin; asynchronous, bouncing.
- Pressed  output  1  debounced level, 1 = pressed.
- PressPulse  output  1  one-cycle pulse when Pressed rises.
- ReleasePulse  output  1  one-cycle pulse when Pressed falls.
- LongPress  output  1  one-cycle pulse, at most once per press.

Behaviour:
- Reset (Reset_n low, async assert):
  - Synchronizer flops load the released level (1 if TACT_ACTIVE_LOW, else 0).
  - State = RELEASED; all counters = 0.
  - Pressed, PressPulse, ReleasePulse and LongPress = 0.
- Reset deassertion is used as-is; no internal reset synchronizer.
- Polarity: s = synchronized Tact XOR TACT_ACTIVE_LOW, so s = 1 means pressed. Only s is used past the chain.
- Debounce counter: width $clog2(DEBOUNCE_CYCLES); the long counter has its own width.
- FSM states and transitions:
  - RELEASED: Pressed = 0. If s = 1: go to CONFIRM_PRESS, counter = 1. Otherwise hold, counter = 0.
  - CONFIRM_PRESS:
    - If s = 0: return to RELEASED, counter = 0 (bounce rejected, no pulse).
    - Else if counter == DEBOUNCE_CYCLES-1: go to HELD, Pressed = 1, PressPulse = 1 for one cycle, long counter = 0.
    - Else counter + 1.
  - HELD:
    - Long counter increments each cycle while below LONG_PRESS_CYCLES-1, then saturates.
    - On the cycle it reaches LONG_PRESS_CYCLES-1: LongPress = 1 for exactly one cycle. No repeat while still held.
    - If s = 0: go to CONFIRM_RELEASE, counter = 1. The long counter freezes (not cleared) until HELD is re-entered.
  - CONFIRM_RELEASE:
    - If s = 1: return to HELD. Pressed stays 1, no pulses, long counter resumes from its frozen value, LongPress is not re-fired.
    - Else if counter == DEBOUNCE_CYCLES-1: go to RELEASED, Pressed = 0, ReleasePulse = 1 for one cycle.
    - Else counter + 1.
- Latency: a clean step on Tact captured at edge k appears on Pressed and PressPulse after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. Release is symmetric.
- All outputs are registered; no combinational path from Tact to any output.
- PressPulse, ReleasePulse and LongPress are mutually exclusive in any cycle.
  - LongPress can never coincide with PressPulse, since LONG_PRESS_CYCLES > DEBOUNCE_CYCLES.
- Pulse widths: bounce shorter than DEBOUNCE_CYCLES produces no output activity.
- Reset mid-operation (any state): immediate return to reset values. A pulse in flight is truncated, and no pulse is emitted on reset release.
- Switch held through reset release: a fresh debounce runs, then PressPulse fires. This is legal.

Decomposition:
- Shared package holds:
  - the state encoding (RELEASED, CONFIRM_PRESS, HELD, CONFIRM_RELEASE; 2-bit);
  - the released-level constant derived from TACT_ACTIVE_LOW.
- One sub-module, sync_chain (parameterised depth, async active-low reset to a parameterised init value). It is reused later for other asynchronous board inputs.
- FSM and counters stay in tact_debouncer.

Test Plan:
Bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32, TACT_ACTIVE_LOW=1.
1. Clean press: Tact 1->0 at edge 10 and held -> Pressed=1 and PressPulse=1 after edge 19, PressPulse=0 at edge 20. No other pulses.
2. Bounce rejection: Tact toggles low for 5 cycles, high for 1, repeated 4 times, then stays high -> Pressed, PressPulse and ReleasePulse remain 0 throughout.
3. Long press: hold low 60 cycles after acceptance -> exactly one LongPress pulse, 31 cycles after PressPulse. Release -> ReleasePulse 8+1 cycles after the release edge propagates. Exactly one of each pulse in total.
4. Release glitch: in HELD at long count 10, Tact high for 3 cycles then low -> Pressed stays 1, no ReleasePulse. LongPress still fires once, delayed by 3 cycles versus an undisturbed press.
5. Reset mid-confirm: Reset_n low for 2 cycles during CONFIRM_PRESS at counter=6 -> all outputs 0 immediately. With Tact still low after release, PressPulse fires exactly after edge 2+8-1 relative to reset release.
6. Polarity: TACT_ACTIVE_LOW=0, repeat scenario 1 with inverted stimulus -> identical output timing.

Source files
------------

// File: rtl/tact_debouncer_pkg.sv
// Shared definitions for the tact switch conditioner: FSM state encoding
// and the released-level helper used to preload the input synchronizer.
package tact_debouncer_pkg;

  // Debounce FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    HELD            = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } state_t;

  // Pin level seen while the switch is not pressed.
  // Active-low switches idle high, active-high switches idle low.
  function automatic logic released_level(input int active_low);
    return (active_low != 0) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/tact_debouncer_sync_chain.sv
// Multi-flop synchronizer for asynchronous board inputs.
// The reset value is a parameter, so an idle input comes out of reset at
// its idle level and no false edge is seen after reset.
module sync_chain #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic D,
  output logic Q
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through the chain; reset loads the idle level.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      chain <= {STAGES{INIT}};
    end else begin
      chain <= {chain[STAGES-2:0], D};
    end
  end

  assign Q = chain[STAGES-1];

endmodule

// File: rtl/tact_debouncer.sv
// Tact switch conditioner: synchronizes the bouncing switch pin, then
// debounces it with a counter-qualified four-state FSM. It produces a clean
// Pressed level, one-cycle press/release events, and a one-shot long-press
// event that feeds the reset-pulse generator.
//
// There are no handshakes. Every output is a registered, free-running
// level or one-cycle pulse. The consumer samples it on any Clock edge, and
// no ready/acknowledge exists.
module tact_debouncer #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int LONG_PRESS_CYCLES = 2000000,
  parameter int TACT_ACTIVE_LOW   = 1
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Tact,
  output logic       Pressed,
  output logic       PressPulse,
  output logic       ReleasePulse,
  output logic       LongPress,
  output logic [1:0] DbgState
);

  import tact_debouncer_pkg::*;

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int LONG_W = $clog2(LONG_PRESS_CYCLES);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_PRE  = LONG_W'(LONG_PRESS_CYCLES - 2);

  localparam logic ACTIVE_LOW   = (TACT_ACTIVE_LOW != 0);
  localparam logic RELEASED_LVL = released_level(TACT_ACTIVE_LOW);

  logic              tact_sync;
  logic              s;
  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [LONG_W-1:0] long_cnt, long_cnt_d;
  logic              pressed_d, press_pulse_d, release_pulse_d, long_press_d;

  sync_chain #(
    .STAGES (SYNC_STAGES),
    .INIT   (RELEASED_LVL)
  ) u_sync (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .D       (Tact),
    .Q       (tact_sync)
  );

  // s = 1 means pressed, whatever the switch polarity.
  assign s = tact_sync ^ ACTIVE_LOW;

  // State and counter registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= RELEASED;
      cnt      <= '0;
      long_cnt <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      long_cnt <= long_cnt_d;
    end
  end

  // Next-state, counter and pulse decisions.
  // The long counter runs in HELD only. It is frozen in CONFIRM_RELEASE, so
  // a release glitch only pauses it. It saturates at its last value, which
  // keeps LongPress to one shot per press.
  always_comb begin
    state_d         = state;
    cnt_d           = cnt;
    long_cnt_d      = long_cnt;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    long_press_d    = 1'b0;
    case (state)
      RELEASED: begin
        if (s) begin
          state_d = CONFIRM_PRESS;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      CONFIRM_PRESS: begin
        if (!s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d       = HELD;
          cnt_d         = '0;
          long_cnt_d    = '0;
          press_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (long_cnt < LONG_LAST) begin
          long_cnt_d = long_cnt + LONG_W'(1);
          if (long_cnt == LONG_PRE) begin
            long_press_d = 1'b1;
          end
        end
        if (!s) begin
          state_d = CONFIRM_RELEASE;
          cnt_d   = CNT_W'(1);
        end
      end
      CONFIRM_RELEASE: begin
        if (s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d         = RELEASED;
          cnt_d           = '0;
          release_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
    pressed_d = (state_d == HELD) || (state_d == CONFIRM_RELEASE);
  end

  // Registered outputs; reset truncates any pulse in flight.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Pressed      <= 1'b0;
      PressPulse   <= 1'b0;
      ReleasePulse <= 1'b0;
      LongPress    <= 1'b0;
    end else begin
      Pressed      <= pressed_d;
      PressPulse   <= press_pulse_d;
      ReleasePulse <= release_pulse_d;
      LongPress    <= long_press_d;
    end
  end

  assign DbgState = state;

endmodule
